// File: rtl/key_press_decoder_pkg.sv
// Shared definitions for the key press decoder and its millisecond timebase.
// Holds the FSM state encoding and the ticks-per-millisecond helper.
package key_press_decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    function automatic int unsigned ticks_per_ms(input int unsigned freq_mhz);
        return freq_mhz * 32'd1000;
    endfunction

endpackage

// File: rtl/key_press_decoder_ms_tick.sv
// Free-running millisecond prescaler: tick is high on the last count before wrap.
// clr restarts the count from 0 so callers can phase-lock the timebase to an event.
module ms_tick_gen
    import key_press_decoder_pkg::*;
#(
    parameter int unsigned N    = 32,
    parameter int unsigned FREQ = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   TPM  = ticks_per_ms(FREQ);
    localparam logic [N-1:0]  LAST = N'(TPM - 32'd1);

    logic [N-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + N'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_press_decoder.sv
// Turns debounced press/release pulses into short-press, long-press and auto-repeat events.
// All outputs registered; event pulses follow their causing condition by one cycle.
module key_press_decoder
    import key_press_decoder_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_press,
    input  logic key_release,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [N-1:0] LONG_C   = N'(LONG_MS);
    localparam logic [N-1:0] REPEAT_C = N'(REPEAT_MS);
    localparam logic [N-1:0] MS_MAX   = (LONG_MS > REPEAT_MS) ? LONG_C : REPEAT_C;

    state_t       state_q, state_d;
    logic [N-1:0] ms_q, ms_d;
    logic         short_q, short_d;
    logic         long_q, long_d;
    logic         rep_q, rep_d;
    logic         held_q;
    logic         tick;
    logic         tick_clr;
    logic         press_ev;
    logic         rel_ev;

    // A simultaneous press and release is not a legal debouncer output; treat it as neither.
    assign press_ev = key_press & ~key_release;
    assign rel_ev   = key_release & ~key_press;

    ms_tick_gen #(
        .N    (N),
        .FREQ (FREQ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        ms_d     = ms_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        tick_clr = 1'b0;
        if (tick && (ms_q != MS_MAX)) begin
            ms_d = ms_q + N'(1);
        end
        case (state_q)
            S_IDLE: begin
                ms_d = '0;
                if (press_ev) begin
                    state_d  = S_PRESSED;
                    tick_clr = 1'b1;
                end
            end
            S_PRESSED: begin
                // Release is checked first so it wins over a coincident threshold.
                if (rel_ev) begin
                    state_d = S_IDLE;
                    short_d = 1'b1;
                end else if (ms_q == LONG_C) begin
                    state_d = S_LONG;
                    long_d  = 1'b1;
                    ms_d    = '0;
                end
            end
            S_LONG: begin
                if (rel_ev) begin
                    state_d = S_IDLE;
                end else if (ms_q == REPEAT_C) begin
                    rep_d = 1'b1;
                    ms_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ms_q    <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= (state_d != S_IDLE);
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign key_held     = held_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder at FREQ=1, LONG_MS=5, REPEAT_MS=2 (1000 cycles per ms).
module tb_key_press_decoder;

    localparam int TPM = 1000;
    localparam int LT  = 5 * TPM + 1;
    localparam int RT  = 2 * TPM;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_press = 1'b0;
    logic key_release = 1'b0;
    logic short_press, long_press, repeat_pulse, key_held;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    bit m_active = 1'b0;
    int m_p = 0;
    int m_d = 0;
    bit e_short = 1'b0, e_long = 1'b0, e_rep = 1'b0, e_held = 1'b0;

    int n_short = 0, n_long = 0;
    int short_at = -1, long_at = -1;
    int rep_at[$];

    key_press_decoder #(
        .N         (32),
        .FREQ      (1),
        .LONG_MS   (5),
        .REPEAT_MS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_press    (key_press),
        .key_release  (key_release),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    // Reference: one tracked press, timed by edge count since the edge that accepted it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_held = 1'b0;
        end else begin
            cyc++;
            e_short = 1'b0; e_long = 1'b0; e_rep = 1'b0;
            if (!m_active) begin
                if (key_press && !key_release) begin
                    m_active = 1'b1;
                    m_p = cyc;
                end
            end else begin
                m_d = cyc - m_p;
                if (key_release && !key_press) begin
                    m_active = 1'b0;
                    e_short = (m_d <= LT);
                end else if (m_d == LT) begin
                    e_long = 1'b1;
                end else if (m_d > LT && ((m_d - LT) % RT) == 0) begin
                    e_rep = 1'b1;
                end
            end
            e_held = m_active;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst) begin
            checks++;
            if ({short_press, long_press, repeat_pulse, key_held} !== {e_short, e_long, e_rep, e_held}) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL cycle_cmp cyc=%0d dut(s,l,r,h)=%b%b%b%b model=%b%b%b%b", cyc,
                             short_press, long_press, repeat_pulse, key_held,
                             e_short, e_long, e_rep, e_held);
            end
            if (short_press === 1'b1) begin n_short++; short_at = cyc; end
            if (long_press === 1'b1) begin n_long++; long_at = cyc; end
            if (repeat_pulse === 1'b1) rep_at.push_back(cyc);
        end
    endtask

    task automatic wait_until(input int edge_no);
        int guard = 0;
        while (cyc < edge_no) begin
            step();
            guard++;
            if (guard > 60000) begin
                failures++;
                $display("FAIL wait_timeout actual_cyc=%0d required_cyc=%0d", cyc, edge_no);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1);
            end
        end
    endtask

    // Drive a one-cycle input pattern so that it is sampled by edge number edge_no.
    task automatic drive(input int edge_no, input bit p, input bit r);
        wait_until(edge_no - 1);
        key_press = p;
        key_release = r;
        step();
        key_press = 1'b0;
        key_release = 1'b0;
    endtask

    task automatic press(output int t0);
        t0 = cyc + 1;
        drive(t0, 1'b1, 1'b0);
    endtask

    task automatic clear_log();
        n_short = 0; n_long = 0; short_at = -1; long_at = -1;
        rep_at.delete();
    endtask

    initial begin
        int t0;
        // Reset state
        #1;
        chk("reset_short", int'(short_press), 0);
        chk("reset_long", int'(long_press), 0);
        chk("reset_repeat", int'(repeat_pulse), 0);
        chk("reset_held", int'(key_held), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) step();

        // Short press
        clear_log();
        press(t0);
        chk("short_held_after_press", int'(key_held), 1);
        drive(t0 + 3001, 1'b0, 1'b1);
        wait_until(t0 + 3010);
        chk("short_count", n_short, 1);
        chk("short_time", short_at, t0 + 3001);
        chk("short_no_long", n_long, 0);
        chk("short_no_repeat", rep_at.size(), 0);

        // Long press with auto-repeat
        clear_log();
        press(t0);
        drive(t0 + 10000, 1'b0, 1'b1);
        wait_until(t0 + 10010);
        chk("long_time", long_at, t0 + 5001);
        chk("long_count", n_long, 1);
        chk("repeat_count", rep_at.size(), 2);
        chk("repeat0_time", (rep_at.size() > 0) ? rep_at[0] : -1, t0 + 7001);
        chk("repeat1_time", (rep_at.size() > 1) ? rep_at[1] : -1, t0 + 9001);
        chk("long_no_short", n_short, 0);

        // Release exactly on the long threshold
        clear_log();
        press(t0);
        drive(t0 + 5001, 1'b0, 1'b1);
        wait_until(t0 + 5010);
        chk("edge_long_short_count", n_short, 1);
        chk("edge_long_short_time", short_at, t0 + 5001);
        chk("edge_long_no_long", n_long, 0);

        // Release exactly on the first repeat threshold
        clear_log();
        press(t0);
        drive(t0 + 7001, 1'b0, 1'b1);
        wait_until(t0 + 7010);
        chk("edge_rep_long_count", n_long, 1);
        chk("edge_rep_no_repeat", rep_at.size(), 0);
        chk("edge_rep_no_short", n_short, 0);

        // Stray pulses
        clear_log();
        drive(cyc + 5, 1'b0, 1'b1);
        chk("stray_release_held", int'(key_held), 0);
        press(t0);
        drive(t0 + 2000, 1'b1, 1'b0);
        drive(t0 + 2500, 1'b1, 1'b1);
        drive(t0 + 5500, 1'b0, 1'b1);
        wait_until(t0 + 5510);
        chk("stray_long_time", long_at, t0 + 5001);
        chk("stray_long_count", n_long, 1);
        chk("stray_no_short", n_short, 0);
        chk("stray_no_repeat", rep_at.size(), 0);

        // Reset in the middle of a press
        clear_log();
        press(t0);
        wait_until(t0 + 4500);
        chk("midreset_held_before", int'(key_held), 1);
        rst = 1'b0;
        #1;
        chk("midreset_held", int'(key_held), 0);
        chk("midreset_short", int'(short_press), 0);
        chk("midreset_long", int'(long_press), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive(cyc + 3, 1'b0, 1'b1);
        wait_until(cyc + 5);
        chk("postreset_release_no_short", n_short, 0);
        chk("postreset_held", int'(key_held), 0);
        clear_log();
        press(t0);
        drive(t0 + 6000, 1'b0, 1'b1);
        wait_until(t0 + 6010);
        chk("postreset_long_time", long_at, t0 + 5001);
        chk("postreset_no_short", n_short, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
